hazard_scoreboard: RTL and testbench

- Produces the decode-stage stall signal (hazard_detected) consumed by the ID stage; it is the return direction of the decode interface.
- Takes the decoded source and destination fields of the instruction in ID.
- Keeps a shift-register scoreboard of destinations in flight in the downstream stages (EXE, MEM, ...).
- Asserts hazard_detected on read-after-write conflicts, inserts bubbles into its own tracker on stall, and holds state while the multicycle memory freezes the pipe.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/sb_match.sv | 24 ++
 rtl/hazard_scoreboard.sv | 98 +++++++++
 tb/tb_hazard_scoreboard.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r_en;
    logic [REG_ADDR_W-1:0] dest;
  } sb_entry_t;

  localparam int unsigned SB_ENTRY_W = $bits(sb_entry_t);

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/sb_match.sv
// Compares one in-flight destination against both ID source fields.
module sb_match
  import hazard_pkg::*;
(
  input  logic [SB_ENTRY_W-1:0] entry,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  use1,
  input  logic                  use2,
  output logic [1:0]            match
);

  sb_entry_t e;
  logic      writes;

  // r0 is never a real write target, so it can never conflict
  always_comb begin
    e        = sb_entry_t'(entry);
    writes   = e.valid & e.wb_en & (e.dest != '0);
    match[0] = use1 & writes & (e.dest == src1);
    match[1] = use2 & writes & (e.dest == src2);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector with a shift-register destination tracker.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned FWD_EN     = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [REG_ADDR_W-1:0]           id_src1,
  input  logic [REG_ADDR_W-1:0]           id_src2,
  input  logic                            id_single_src,
  input  logic                            id_store_bne,
  input  logic [REG_ADDR_W-1:0]           id_dest,
  input  logic                            id_wb_en,
  input  logic                            id_mem_r_en,
  input  logic                            flush,
  input  logic                            freeze,
  output logic                            hazard_detected,
  output logic [$clog2(PIPE_DEPTH+1)-1:0] in_flight,
  output logic [CNT_W-1:0]                stall_count
);

  localparam int unsigned IF_W = $clog2(PIPE_DEPTH + 1);

  sb_entry_t                 entries     [PIPE_DEPTH];
  sb_entry_t                 entries_nxt [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0][1:0] match;
  logic                      use1;
  logic                      use2;
  logic                      raw_hazard;
  logic [IF_W-1:0]           in_flight_nxt;

  assign use1 = id_valid;
  assign use2 = id_valid & (~id_single_src | id_store_bne);

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_match
    sb_match u_match (
      .entry (entries[g]),
      .src1  (id_src1),
      .src2  (id_src2),
      .use1  (use1),
      .use2  (use2),
      .match (match[g])
    );
  end

  // Stall decision: all stages without forwarding, load-use on EXE only with it
  always_comb begin
    raw_hazard = 1'b0;
    if (FWD_EN != 0) begin
      raw_hazard = entries[0].mem_r_en & (|match[0]);
    end else begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        raw_hazard = raw_hazard | (|match[i]);
      end
    end
    hazard_detected = raw_hazard & ~rst;
  end

  // Next tracker contents and the writer count they imply
  always_comb begin
    for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
      entries_nxt[i] = entries[i-1];
    end
    if (hazard_detected | flush | ~id_valid) begin
      entries_nxt[0] = SB_BUBBLE;
    end else begin
      entries_nxt[0] = '{valid: 1'b1, wb_en: id_wb_en, mem_r_en: id_mem_r_en, dest: id_dest};
    end
    in_flight_nxt = '0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      in_flight_nxt = in_flight_nxt + IF_W'(entries_nxt[i].valid & entries_nxt[i].wb_en);
    end
  end

  // Tracker, writer count and saturating stall counter; freeze holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        entries[i] <= SB_BUBBLE;
      end
      in_flight   <= '0;
      stall_count <= '0;
    end else if (!freeze) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        entries[i] <= entries_nxt[i];
      end
      in_flight <= in_flight_nxt;
      if (hazard_detected && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: dut0 = default build, dut1 = forwarding build with a 2-bit counter.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       single;
    logic       sbne;
    logic [4:0] dest;
    logic       wb;
    logic       mr;
    logic       flush;
    logic       freeze;
    logic       rst;
  } in_t;

  typedef struct {
    int          sel;
    logic        haz;
    logic [1:0]  inf;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  in_t         in0;
  in_t         in1;
  logic        haz0, haz1;
  logic [1:0]  inf0, inf1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.PIPE_DEPTH(2), .FWD_EN(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(in0.rst), .id_valid(in0.valid), .id_src1(in0.src1), .id_src2(in0.src2),
    .id_single_src(in0.single), .id_store_bne(in0.sbne), .id_dest(in0.dest),
    .id_wb_en(in0.wb), .id_mem_r_en(in0.mr), .flush(in0.flush), .freeze(in0.freeze),
    .hazard_detected(haz0), .in_flight(inf0), .stall_count(cnt0)
  );

  hazard_scoreboard #(.PIPE_DEPTH(2), .FWD_EN(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(in1.rst), .id_valid(in1.valid), .id_src1(in1.src1), .id_src2(in1.src2),
    .id_single_src(in1.single), .id_store_bne(in1.sbne), .id_dest(in1.dest),
    .id_wb_en(in1.wb), .id_mem_r_en(in1.mr), .flush(in1.flush), .freeze(in1.freeze),
    .hazard_detected(haz1), .in_flight(inf1), .stall_count(cnt1)
  );

  function automatic in_t nop();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t ins(int s1, int s2, bit single, bit sbne, int dest, bit wb, bit mr);
    in_t v;
    v        = '0;
    v.valid  = 1'b1;
    v.src1   = 5'(s1);
    v.src2   = 5'(s2);
    v.single = single;
    v.sbne   = sbne;
    v.dest   = 5'(dest);
    v.wb     = wb;
    v.mr     = mr;
    return v;
  endfunction

  function automatic in_t fz(in_t v);
    in_t r;
    r        = v;
    r.freeze = 1'b1;
    return r;
  endfunction

  function automatic in_t fl(in_t v);
    in_t r;
    r       = v;
    r.flush = 1'b1;
    return r;
  endfunction

  function automatic in_t rs(in_t v);
    in_t r;
    r     = v;
    r.rst = 1'b1;
    return r;
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected during it
  task automatic cyc(input int sel, input in_t v, input int eh, input int ei, input int ec,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel == 0) begin
      in0 = v;
      in1 = nop();
    end else begin
      in1 = v;
      in0 = nop();
    end
    e.sel  = sel;
    e.haz  = 1'(eh);
    e.inf  = 2'(ei);
    e.cnt  = 16'(ec);
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: compares each queued expectation mid-cycle
  initial begin
    exp_t        e;
    logic        ah;
    logic [1:0]  ai;
    logic [15:0] ac;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        ah = (e.sel == 0) ? haz0 : haz1;
        ai = (e.sel == 0) ? inf0 : inf1;
        ac = (e.sel == 0) ? cnt0 : {14'b0, cnt1};
        checks++;
        if (ah !== e.haz) begin
          errors++;
          $display("FAIL %s hazard: got %0b expected %0b", e.name, ah, e.haz);
        end
        checks++;
        if (ai !== e.inf) begin
          errors++;
          $display("FAIL %s in_flight: got %0d expected %0d", e.name, ai, e.inf);
        end
        checks++;
        if (ac !== e.cnt) begin
          errors++;
          $display("FAIL %s stall_count: got %0d expected %0d", e.name, ac, e.cnt);
        end
      end
    end
  end

  initial begin
    in_t add3, sub3, r5, st5, lw6, rd6, add4, rd4, lw4, rdl;
    int  c, c1;
    add3 = ins(1, 2, 0, 0, 3, 1, 0);
    sub3 = ins(3, 4, 0, 0, 7, 1, 0);
    r5   = ins(1, 0, 1, 0, 5, 1, 0);
    st5  = ins(2, 5, 1, 1, 0, 0, 0);
    lw6  = ins(1, 0, 1, 0, 6, 1, 1);
    rd6  = ins(6, 7, 0, 0, 9, 1, 0);
    add4 = ins(1, 2, 0, 0, 4, 1, 0);
    rd4  = ins(4, 5, 0, 0, 10, 1, 0);
    lw4  = ins(1, 0, 1, 0, 4, 1, 1);
    rdl  = ins(3, 4, 0, 0, 0, 0, 0);

    in0 = rs(nop());
    in1 = rs(nop());
    repeat (2) @(posedge clk);

    cyc(0, nop(), 0, 0, 0, "reset");
    // RAW on rs, two stall cycles then resolved
    cyc(0, add3,  0, 0, 0, "t1_add");
    cyc(0, sub3,  1, 1, 0, "t1_stall1");
    cyc(0, sub3,  1, 1, 1, "t1_stall2");
    cyc(0, sub3,  0, 0, 2, "t1_go");
    cyc(0, nop(), 0, 1, 2, "t1_d1");
    cyc(0, nop(), 0, 1, 2, "t1_d2");
    cyc(0, nop(), 0, 0, 2, "t1_d3");
    // r0 never conflicts
    cyc(0, ins(1, 0, 1, 0, 0, 1, 0), 0, 0, 2, "t2_addi_r0");
    cyc(0, ins(0, 0, 0, 0, 0, 0, 0), 0, 1, 2, "t2_read_r0");
    cyc(0, nop(), 0, 1, 2, "t2_d1");
    cyc(0, nop(), 0, 0, 2, "t2_d2");
    // rt ignored for single-source, used for store/BNE
    cyc(0, r5,    0, 0, 2, "t3_r5");
    cyc(0, ins(2, 5, 1, 0, 6, 1, 0), 0, 1, 2, "t3_single");
    cyc(0, nop(), 0, 2, 2, "t3_d1");
    cyc(0, nop(), 0, 1, 2, "t3_d2");
    cyc(0, r5,    0, 0, 2, "t3_r5b");
    cyc(0, st5,   1, 1, 2, "t3_st_stall1");
    cyc(0, st5,   1, 1, 3, "t3_st_stall2");
    cyc(0, st5,   0, 0, 4, "t3_st_go");
    cyc(0, nop(), 0, 0, 4, "t3_d3");
    cyc(0, nop(), 0, 0, 4, "t3_d4");
    // freeze holds tracker and counter while hazard stays visible
    cyc(0, lw6,   0, 0, 4, "t5_lw");
    for (int i = 0; i < 5; i++) cyc(0, fz(rd6), 1, 1, 4, "t5_frozen");
    cyc(0, rd6,   1, 1, 4, "t5_stall1");
    cyc(0, rd6,   1, 1, 5, "t5_stall2");
    cyc(0, rd6,   0, 0, 6, "t5_go");
    cyc(0, nop(), 0, 1, 6, "t5_d1");
    cyc(0, nop(), 0, 1, 6, "t5_d2");
    cyc(0, nop(), 0, 0, 6, "t5_d3");
    // flush with hazard gives one bubble; flush alone squashes
    cyc(0, add3,     0, 0, 6, "t6_add");
    cyc(0, fl(sub3), 1, 1, 6, "t6_flush_haz");
    cyc(0, nop(),    0, 1, 7, "t6_d1");
    cyc(0, nop(),    0, 0, 7, "t6_d2");
    cyc(0, fl(add3), 0, 0, 7, "t6_flush_only");
    cyc(0, nop(),    0, 0, 7, "t6_d3");
    // reset mid-stall clears everything
    cyc(0, add3,         0, 0, 7, "t6_add2");
    cyc(0, sub3,         1, 1, 7, "t6_stall");
    cyc(0, rs(fl(sub3)), 0, 1, 8, "t6_rst");
    cyc(0, sub3,         0, 0, 0, "t6_after_rst");
    cyc(0, nop(),        0, 1, 0, "t6_d4");
    cyc(0, nop(),        0, 1, 0, "t6_d5");
    cyc(0, nop(),        0, 0, 0, "t6_d6");
    // forwarding build: ALU results never stall, load-use stalls once
    cyc(1, add4,  0, 0, 0, "t4_add");
    cyc(1, rd4,   0, 1, 0, "t4_fwd");
    cyc(1, nop(), 0, 2, 0, "t4_d1");
    cyc(1, nop(), 0, 1, 0, "t4_d2");
    cyc(1, nop(), 0, 0, 0, "t4_d3");
    for (int k = 0; k < 4; k++) begin
      c  = (k < 3) ? k : 3;
      c1 = (k + 1 < 3) ? k + 1 : 3;
      cyc(1, lw4,   0, 0, c,  "t4_lw");
      cyc(1, rdl,   1, 1, c,  "t4_load_use");
      cyc(1, rdl,   0, 1, c1, "t4_go");
      cyc(1, nop(), 0, 0, c1, "t4_idle");
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
